// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the single-port data memory and its load aligner.
package data_memory_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Per-slot response metadata carried alongside the read word.
  typedef struct packed {
    logic       valid;
    logic       mis;
    logic [1:0] off;
    logic [1:0] size;
    logic       uns;
  } resp_meta_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Lane select and sign/zero extension of a 32-bit memory word for sub-word loads.
module mem_load_align
  import data_memory_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    data_o   = '0;
    byte_sel = word_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      SZ_BYTE: data_o = {{24{~uns_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: data_o = {{16{~uns_i & half_sel[15]}}, half_sel};
      SZ_WORD: data_o = word_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_sp.sv
// Single-port MEM-stage data memory: init sweep after reset, byte-lane writes,
// sub-word loads with extension, and a READ_LAT-deep registered response pipe.
module data_memory_sp
  import data_memory_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned READ_LAT  = 1,
  parameter int unsigned INIT_MODE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_enable,
  input  logic        mem_write_enable,
  input  logic [31:0] address,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] write_data,
  output logic        ready,
  output logic [31:0] data,
  output logic        data_valid,
  output logic        misaligned
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  logic          accept;
  logic [AW-1:0] req_idx;
  logic [AW-1:0] wr_idx;
  logic [1:0]    off;
  logic          bad;
  logic [3:0]    lane_we;
  logic [31:0]   wr_word;
  logic [31:0]   aligned;
  logic          unused_addr;

  resp_meta_t    meta_d;
  resp_meta_t    meta_last;
  resp_meta_t    meta_q [READ_LAT];
  logic [31:0]   word_q [READ_LAT];
  logic [31:0]   mem_q  [DEPTH];

  assign accept      = (state_q == RUN);
  assign req_idx     = address[AW+1:2];
  assign off         = address[1:0];
  assign bad         = is_misaligned(size, off);
  assign unused_addr = ^address[31:AW+2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == AW'(DEPTH - 1)) begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The single write port is shared between the init sweep and store requests.
  always_comb begin
    lane_we = '0;
    wr_idx  = req_idx;
    wr_word = write_data;
    if (reset) begin
      if (state_q == INIT) begin
        lane_we = 4'b1111;
        wr_idx  = cnt_q;
        wr_word = (INIT_MODE != 0) ? 32'(cnt_q) : 32'd0;
      end else if (mem_write_enable && !bad) begin
        case (size)
          SZ_BYTE: begin
            lane_we = 4'b0001 << off;
            wr_word = {4{write_data[7:0]}};
          end
          SZ_HALF: begin
            lane_we = off[1] ? 4'b1100 : 4'b0011;
            wr_word = {2{write_data[15:0]}};
          end
          default: lane_we = 4'b1111;
        endcase
      end
    end
  end

  always_comb begin
    meta_d       = '0;
    meta_d.valid = accept & mem_read_enable;
    meta_d.mis   = accept & (mem_read_enable | mem_write_enable) & bad;
    meta_d.off   = off;
    meta_d.size  = size;
    meta_d.uns   = load_unsigned;
  end

  // Read and write share an edge, so a same-cycle read sees the pre-write word.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (lane_we[b]) begin
        mem_q[wr_idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
    word_q[0] <= mem_q[req_idx];
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 1; i < READ_LAT; i++) begin
      word_q[i] <= word_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < READ_LAT; i++) begin
        meta_q[i] <= '0;
      end
    end else begin
      meta_q[0] <= meta_d;
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        meta_q[i] <= meta_q[i-1];
      end
    end
  end

  assign meta_last = meta_q[READ_LAT-1];

  mem_load_align u_align (
    .word_i (word_q[READ_LAT-1]),
    .off_i  (meta_last.off),
    .size_i (meta_last.size),
    .uns_i  (meta_last.uns),
    .data_o (aligned)
  );

  assign ready      = accept;
  assign data_valid = meta_last.valid;
  assign misaligned = meta_last.mis;
  assign data       = (meta_last.valid && !meta_last.mis) ? aligned : 32'd0;

endmodule

// File: tb/tb_data_memory_sp.sv
// Bench for data_memory_sp: two instances (DEPTH 8 / lat 1, DEPTH 64 / lat 3) share stimulus
// and are checked every cycle against a word-array model plus literal expectations.
module tb_data_memory_sp;

  localparam int DA = 8;
  localparam int LA = 1;
  localparam int DB = 64;
  localparam int LB = 3;

  logic        clk;
  logic        reset;
  logic        rd_en, wr_en, uns;
  logic [31:0] addr, wdata;
  logic [1:0]  sz;

  logic        rdy_a, dv_a, mis_a, rdy_b, dv_b, mis_b;
  logic [31:0] dat_a, dat_b;

  data_memory_sp #(.DEPTH(DA), .READ_LAT(LA), .INIT_MODE(1)) dut_a (
    .clk              (clk),
    .reset            (reset),
    .mem_read_enable  (rd_en),
    .mem_write_enable (wr_en),
    .address          (addr),
    .size             (sz),
    .load_unsigned    (uns),
    .write_data       (wdata),
    .ready            (rdy_a),
    .data             (dat_a),
    .data_valid       (dv_a),
    .misaligned       (mis_a)
  );

  data_memory_sp #(.DEPTH(DB), .READ_LAT(LB), .INIT_MODE(1)) dut_b (
    .clk              (clk),
    .reset            (reset),
    .mem_read_enable  (rd_en),
    .mem_write_enable (wr_en),
    .address          (addr),
    .size             (sz),
    .load_unsigned    (uns),
    .write_data       (wdata),
    .ready            (rdy_b),
    .data             (dat_b),
    .data_valid       (dv_b),
    .misaligned       (mis_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Behavioural model state, per instance k.
  logic [31:0] mm   [2][64];
  bit          run  [2];
  int          cnt  [2];
  logic        sv   [2][4];
  logic        sm   [2][4];
  logic [31:0] sd   [2][4];

  // Literal expectations: {valid, mis, data} due at a given cycle for instance k.
  int          lq_due  [$];
  int          lq_k    [$];
  string       lq_name [$];
  logic [33:0] lq_exp  [$];

  function automatic int dep_of(int k);
    return (k == 0) ? DA : DB;
  endfunction

  function automatic int lat_of(int k);
    return (k == 0) ? LA : LB;
  endfunction

  function automatic logic [31:0] ld_val(logic [31:0] w, int off, int szv, bit u);
    longint unsigned mask, raw;
    int nbits;
    nbits = 8 << szv;
    mask  = (64'd1 << nbits) - 64'd1;
    raw   = ({32'd0, w} >> (8 * off)) & mask;
    if (!u && raw[nbits-1]) raw = raw | ~mask;
    return raw[31:0];
  endfunction

  function automatic logic [31:0] st_val(logic [31:0] old, logic [31:0] wd, int off, int szv);
    longint unsigned mask, r;
    mask = ((64'd1 << (8 << szv)) - 64'd1) << (8 * off);
    r    = ({32'd0, old} & ~mask) | (({32'd0, wd} << (8 * off)) & mask);
    return r[31:0];
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int d_k, l_k, idx, off;
      logic nv, nm, badm;
      logic [31:0] nd, old;
      d_k = dep_of(k);
      l_k = lat_of(k);
      nv = 1'b0; nm = 1'b0; nd = 32'd0;
      for (int i = l_k - 1; i > 0; i--) begin
        sv[k][i] = sv[k][i-1]; sm[k][i] = sm[k][i-1]; sd[k][i] = sd[k][i-1];
      end
      if (!reset) begin
        run[k] = 1'b0;
        cnt[k] = 0;
        for (int i = 0; i < 4; i++) begin
          sv[k][i] = 1'b0; sm[k][i] = 1'b0; sd[k][i] = 32'd0;
        end
      end else if (!run[k]) begin
        mm[k][cnt[k]] = 32'(cnt[k]);
        cnt[k]++;
        if (cnt[k] == d_k) run[k] = 1'b1;
      end else begin
        idx  = int'((addr >> 2) % d_k);
        off  = int'(addr & 32'd3);
        badm = (sz == 2'b11) || (sz == 2'b01 && off[0]) || (sz == 2'b10 && off != 0);
        old  = mm[k][idx];
        nv   = rd_en;
        nm   = (rd_en || wr_en) && badm;
        if (rd_en && !badm) nd = ld_val(old, off, int'(sz), uns);
        if (wr_en && !badm) mm[k][idx] = st_val(old, wdata, off, int'(sz));
      end
      sv[k][0] = nv; sm[k][0] = nm; sd[k][0] = nd;
    end
  endtask

  always @(posedge clk) begin
    model_step();
    cyc++;
  end

  // Per-cycle comparison against the model, plus any literal expectations now due.
  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int k = 0; k < 2; k++) begin
        logic        g_r, g_v, g_m;
        logic [31:0] g_d;
        int          l_k;
        l_k = lat_of(k);
        g_r = (k == 0) ? rdy_a : rdy_b;
        g_v = (k == 0) ? dv_a  : dv_b;
        g_m = (k == 0) ? mis_a : mis_b;
        g_d = (k == 0) ? dat_a : dat_b;
        n_cmp++;
        if (g_r !== logic'(run[k]) || g_v !== sv[k][l_k-1] || g_m !== sm[k][l_k-1]
            || g_d !== sd[k][l_k-1]) begin
          n_bad++;
          $display("FAIL model_k%0d cyc=%0d got rdy=%b v=%b m=%b d=%h want rdy=%b v=%b m=%b d=%h",
                   k, cyc, g_r, g_v, g_m, g_d, run[k], sv[k][l_k-1], sm[k][l_k-1], sd[k][l_k-1]);
        end
      end
      for (int i = lq_due.size() - 1; i >= 0; i--) begin
        if (lq_due[i] == cyc) begin
          logic [33:0] got;
          got = (lq_k[i] == 0) ? {dv_a, mis_a, dat_a} : {dv_b, mis_b, dat_b};
          n_cmp++;
          if (got !== lq_exp[i]) begin
            n_bad++;
            $display("FAIL %s k%0d got v/m/d=%b/%b/%h want %b/%b/%h", lq_name[i], lq_k[i],
                     got[33], got[32], got[31:0], lq_exp[i][33], lq_exp[i][32], lq_exp[i][31:0]);
          end
          lq_due.delete(i); lq_k.delete(i); lq_name.delete(i); lq_exp.delete(i);
        end
      end
    end
  end

  task automatic expect_lit(string name, logic v, logic m, logic [31:0] d);
    for (int k = 0; k < 2; k++) begin
      lq_due.push_back(cyc + lat_of(k));
      lq_k.push_back(k);
      lq_name.push_back(name);
      lq_exp.push_back({v, m, d});
    end
  endtask

  task automatic check_bit(string name, logic got, logic want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  // Drive one request at the current negedge and advance to the next negedge.
  task automatic req(bit r, bit w, logic [31:0] a, logic [1:0] s, bit u, logic [31:0] wd);
    rd_en = r; wr_en = w; addr = a; sz = s; uns = u; wdata = wd;
    @(negedge clk);
  endtask

  task automatic idle();
    req(1'b0, 1'b0, 32'd0, 2'b10, 1'b0, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    rd_en = 1'b0; wr_en = 1'b0; addr = '0; sz = 2'b10; uns = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    repeat (7) @(negedge clk);
    check_bit("ready_a_cycle7", rdy_a, 1'b0);
    @(negedge clk);
    check_bit("ready_a_cycle8", rdy_a, 1'b1);
    repeat (55) @(negedge clk);
    check_bit("ready_b_cycle63", rdy_b, 1'b0);
    @(negedge clk);
    check_bit("ready_b_cycle64", rdy_b, 1'b1);

    expect_lit("lw_0x14", 1'b1, 1'b0, 32'h0000_0005);
    req(1, 0, 32'h14, 2'b10, 0, 32'h0);
    expect_lit("sw_0x0_resp", 1'b0, 1'b0, 32'h0);
    req(0, 1, 32'h0, 2'b10, 0, 32'h80FF_7F01);
    expect_lit("lb_0x0", 1'b1, 1'b0, 32'h0000_0001);
    req(1, 0, 32'h0, 2'b00, 0, 32'h0);
    expect_lit("lb_0x2", 1'b1, 1'b0, 32'hFFFF_FFFF);
    req(1, 0, 32'h2, 2'b00, 0, 32'h0);
    expect_lit("lbu_0x2", 1'b1, 1'b0, 32'h0000_00FF);
    req(1, 0, 32'h2, 2'b00, 1, 32'h0);
    expect_lit("lh_0x2", 1'b1, 1'b0, 32'hFFFF_80FF);
    req(1, 0, 32'h2, 2'b01, 0, 32'h0);
    expect_lit("lhu_0x2", 1'b1, 1'b0, 32'h0000_80FF);
    req(1, 0, 32'h2, 2'b01, 1, 32'h0);
    req(0, 1, 32'h5, 2'b00, 0, 32'h0000_00AB);
    expect_lit("lw_0x4_after_sb", 1'b1, 1'b0, 32'h0000_AB01);
    req(1, 0, 32'h4, 2'b10, 0, 32'h0);
    expect_lit("sw_0x6_misaligned", 1'b0, 1'b1, 32'h0);
    req(0, 1, 32'h6, 2'b10, 0, 32'hDEAD_BEEF);
    expect_lit("lw_0x4_unchanged", 1'b1, 1'b0, 32'h0000_AB01);
    req(1, 0, 32'h4, 2'b10, 0, 32'h0);
    expect_lit("lh_0x3_misaligned", 1'b1, 1'b1, 32'h0);
    req(1, 0, 32'h3, 2'b01, 0, 32'h0);
    expect_lit("rw_0x8_old", 1'b1, 1'b0, 32'h0000_0002);
    req(1, 1, 32'h8, 2'b10, 0, 32'h1234_5678);
    expect_lit("lw_0x8_new", 1'b1, 1'b0, 32'h1234_5678);
    req(1, 0, 32'h8, 2'b10, 0, 32'h0);
    repeat (5) idle();

    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 63));
      req(bit'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), a,
          2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), $urandom);
    end
    repeat (5) idle();

    for (int i = 0; i < 4; i++) req(1, 0, 32'(4 * i), 2'b10, 0, 32'h0);
    reset = 1'b0;
    req(1, 0, 32'h10, 2'b10, 0, 32'h0);
    check_bit("dv_a_after_reset", dv_a, 1'b0);
    check_bit("dv_b_after_reset", dv_b, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req(1, 0, 32'(4 * i), 2'b10, 0, 32'h0);
      check_bit("dv_b_during_init", dv_b, 1'b0);
    end
    repeat (64) idle();
    expect_lit("lw_0x8_reinit", 1'b1, 1'b0, 32'h0000_0002);
    req(1, 0, 32'h8, 2'b10, 0, 32'h0);
    expect_lit("lw_0x0_reinit", 1'b1, 1'b0, 32'h0000_0000);
    req(1, 0, 32'h0, 2'b10, 0, 32'h0);
    repeat (6) idle();

    n_cmp++;
    if (lq_due.size() != 0) begin
      n_bad++;
      $display("FAIL literal_drain got %0d pending want 0", lq_due.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_memory_sp.md
# data_memory_sp

Parametrised single-port data memory for the pipeline MEM stage, successor to the fixed 8-word memory. Adds configurable depth and read latency, byte/half/word accesses with sign or zero extension, byte-lane writes, misalignment detection, and a hardware initialisation sweep after reset. It sits between the EX/MEM pipeline register and the MEM/WB write-back mux.

## Interface
- DEPTH, 256, number of 32-bit words; power of two, 8..4096
- READ_LAT, 1, read latency in cycles, 1..4
- INIT_MODE, 1, post-reset contents: 0 = all zero, 1 = word i holds value i
- clk  in  1  rising-edge clock, the single clock domain
- reset  in  1  synchronous, active-low reset; sampled on rising clk
- mem_read_enable  in  1  read request
- mem_write_enable  in  1  write request
- address  in  32  byte address; little-endian
- size  in  2  00 byte, 01 half, 10 word, 11 reserved
- load_unsigned  in  1  1 = zero-extend sub-word loads, 0 = sign-extend
- write_data  in  32  store data; byte/half taken from low bits
- ready  out  1  1 when requests are accepted
- data  out  32  read data, extended to 32 bits
- data_valid  out  1  data/misaligned are valid this cycle
- misaligned  out  1  accepted access was misaligned or used size 11

## Operation
- Word index = address[log2(DEPTH)+1:2]; higher bits ignored, so addresses alias modulo 4*DEPTH.
- Misaligned: half with address[0]=1, word with address[1:0]!=0, or size 11.
- FSM states INIT, RUN. Reset low forces INIT with sweep counter 0. Each INIT cycle with reset high writes the INIT_MODE value into word counter; after word DEPTH-1 is written, RUN. ready = (state==RUN).
- Requests with ready=0 are ignored, with no write and no response.
- Aligned write: updates only the addressed byte lanes (byte: lane address[1:0]; half: lanes address[1]*2..+1; word: all).
- Misaligned write: array unchanged; response slot carries misaligned=1, data=0, data_valid=0.
- Aligned read: selects lanes, extends per load_unsigned, data_valid=1, misaligned=0.
- Misaligned read: data=0, data_valid=1, misaligned=1.
- Read and write in the same cycle: write is performed; read returns the pre-write word.
- Cycles without an accepted read: data=0 and data_valid=0 in the corresponding response slot, as in the legacy block.

## Timing
- Reset values: ready=0, data=0, data_valid=0, misaligned=0, sweep counter=0, response pipeline cleared.
- INIT lasts exactly DEPTH cycles after the first cycle that samples reset high. ready rises in the following cycle.
- A request presented in cycle N produces its response in cycle N+READ_LAT. Outputs are registered. Stage 1 reads the array; later stages only delay.
- Throughput: one request per cycle. No back-pressure once in RUN.
- A write in cycle N is visible to a read presented in cycle N+1 for any READ_LAT.
- Reset asserted mid-operation discards in-flight responses; outputs are 0 from the next edge. Contents are reinitialised by the new INIT sweep.
- Reset asserted mid-INIT restarts the sweep from word 0.

## Structure
- Package data_memory_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD
  - state enum INIT/RUN
  - the misalignment predicate function
- Sub-module mem_load_align: combinational lane select and sign/zero extension (word, address[1:0], size, load_unsigned -> 32-bit data). It is reused by the later cache block.
- The array is a plain reg array suitable for block-RAM inference. Byte-lane writes use per-lane enables.

## Test plan
- Reset then release, DEPTH=8, INIT_MODE=1: ready=0 for 8 cycles then 1. Word read at 0x14 -> data=0x00000005, data_valid=1, READ_LAT cycles later.
- Store word 0x80FF7F01 at 0x0, then lb 0x0 -> 0x00000001; lb 0x2 -> 0xFFFFFFFF; lbu 0x2 -> 0x000000FF; lh 0x2 -> 0xFFFF80FF; lhu 0x2 -> 0x000080FF.
- sb 0xAB at 0x5 over word 0x00000001 -> subsequent word read at 0x4 returns 0x0000AB01.
- Word write at 0x6 (misaligned) -> misaligned=1, array unchanged; half read at 0x3 -> data=0, data_valid=1, misaligned=1.
- Simultaneous read+write at 0x8 with new data 0x12345678 -> read returns the old value; next-cycle read returns 0x12345678. Repeat with READ_LAT=3.
- Back-to-back reads with READ_LAT=3 and reset pulsed low mid-stream -> no data_valid after the reset edge. A 64-word INIT sweep restarts (DEPTH=64) and the old contents are gone.
